// File: rtl/prio_enc_pend.sv
// Registered priority encoder with sticky pending bits and a valid/ready grant port.
// Define IRQ_MASK_EN to add a per-request eligibility mask input.
module prio_enc_pend #(
    parameter int N  = 8,
    parameter int RR = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
`ifdef IRQ_MASK_EN
    input  logic [N-1:0] mask,
`endif
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] y,
    output logic [N-1:0] pend,
    output logic         any
);

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] pend_next;
    logic [N-1:0] elig;
    logic [W-1:0] last;
    logic [W-1:0] base;
    logic [W-1:0] sel;

    // A request arriving on the bit being retired this cycle keeps it pending.
    always_comb begin
        accept = valid && ready;
        clr    = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && (int'(y) == i)) clr[i] = 1'b1;
        end
        pend_next = (pend & ~clr) | req;
`ifdef IRQ_MASK_EN
        elig = pend_next & mask;
`else
        elig = pend_next;
`endif
    end

    // Round-robin searches down from the index just accepted, so the search
    // base follows y in the accept cycle rather than the stale last register.
    always_comb begin
        base = accept ? y : last;
        sel  = '0;
        if (RR != 0) begin
            for (int off = N; off >= 1; off--) begin
                if (elig[(int'(base) + N - off) % N]) sel = W'((int'(base) + N - off) % N);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) sel = W'(i);
            end
        end
    end

    assign any = |pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            valid <= 1'b0;
            y     <= '0;
            last  <= '0;
        end else begin
            pend <= pend_next;
            if (!valid || accept) begin
                valid <= en && (|elig);
                if (|elig) y <= sel;
            end
            if (accept) last <= y;
        end
    end

endmodule

// File: tb/tb_prio_enc_pend.sv
// Directed self-checking bench for prio_enc_pend: fixed N=8, round-robin N=8 and N=5.
// Mask tests run only when IRQ_MASK_EN is defined.
module tb_prio_enc_pend;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic       ready;
        logic       expValid;
        logic [2:0] expY;
        logic [7:0] expPend;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] y;
    logic [7:0] pend;
    logic       any;
    logic [7:0] mask8;

    logic [7:0] rr8Req;
    logic       rr8Ready;
    logic       rr8Valid;
    logic [2:0] rr8Y;
    logic [7:0] rr8Pend;
    logic       rr8Any;

    logic [4:0] rr5Req;
    logic       rr5Ready;
    logic       rr5Valid;
    logic [2:0] rr5Y;
    logic [4:0] rr5Pend;
    logic       rr5Any;

    int errors = 0;
    int checks = 0;
    vec_t vecs[25];

    prio_enc_pend #(.N(8), .RR(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
`ifdef IRQ_MASK_EN
        .mask(mask8),
`endif
        .ready(ready), .valid(valid), .y(y), .pend(pend), .any(any)
    );

    prio_enc_pend #(.N(8), .RR(1)) rr8 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .req(rr8Req),
`ifdef IRQ_MASK_EN
        .mask(8'hFF),
`endif
        .ready(rr8Ready), .valid(rr8Valid), .y(rr8Y), .pend(rr8Pend), .any(rr8Any)
    );

    prio_enc_pend #(.N(5), .RR(1)) rr5 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .req(rr5Req),
`ifdef IRQ_MASK_EN
        .mask(5'h1F),
`endif
        .ready(rr5Ready), .valid(rr5Valid), .y(rr5Y), .pend(rr5Pend), .any(rr5Any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic e, input logic rd);
        req   = r;
        en    = e;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic v, input logic [2:0] yy, input logic [7:0] p);
        checkOutput({tag, ".valid"}, int'(valid), int'(v));
        checkOutput({tag, ".y"}, int'(y), int'(yy));
        checkOutput({tag, ".pend"}, int'(pend), int'(p));
        checkOutput({tag, ".any"}, int'(any), int'(|p));
    endtask

    initial begin
        logic [2:0] rr8Exp[6];
        logic [2:0] rr5Exp[5];
        rr8Exp = '{3'd7, 3'd4, 3'd0, 3'd7, 3'd4, 3'd0};
        rr5Exp = '{3'd4, 3'd2, 3'd0, 3'd4, 3'd2};

        // fixed drain, hold/no-preempt, set-wins, enable gating, constant request
        vecs[0]  = '{8'h26, 1'b1, 1'b1, 1'b1, 3'd5, 8'h26};
        vecs[1]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h06};
        vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02};
        vecs[3]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00};
        vecs[4]  = '{8'h08, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08};
        vecs[5]  = '{8'h80, 1'b1, 1'b0, 1'b1, 3'd3, 8'h88};
        vecs[6]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h88};
        vecs[7]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00};
        vecs[9]  = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04};
        vecs[10] = '{8'h04, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04};
        vecs[11] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00};
        vecs[12] = '{8'h10, 1'b0, 1'b1, 1'b0, 3'd4, 8'h10};
        vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h10};
        vecs[14] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10};
        vecs[15] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 8'h00};
        vecs[16] = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02};
        vecs[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00};
        vecs[19] = '{8'h91, 1'b1, 1'b1, 1'b1, 3'd7, 8'h91};
        vecs[20] = '{8'h91, 1'b1, 1'b1, 1'b1, 3'd7, 8'h91};
        vecs[21] = '{8'h91, 1'b1, 1'b1, 1'b1, 3'd7, 8'h91};
        vecs[22] = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 8'h11};
        vecs[23] = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
        vecs[24] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};

        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 8'h00;
        ready    = 1'b0;
        mask8    = 8'hFF;
        rr8Req   = 8'h00;
        rr8Ready = 1'b0;
        rr5Req   = 5'h00;
        rr5Ready = 1'b0;

        #2;
        checkMain("reset", 1'b0, 3'd0, 8'h00);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].req, vecs[i].en, vecs[i].ready);
            checkMain($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expY, vecs[i].expPend);
        end

        // round-robin N=8: constant request rotates through 7, 4, 0
        for (int i = 0; i < 6; i++) begin
            rr8Req   = 8'h91;
            rr8Ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("rr8.valid%0d", i), int'(rr8Valid), 1);
            checkOutput($sformatf("rr8.y%0d", i), int'(rr8Y), int'(rr8Exp[i]));
            checkOutput($sformatf("rr8.pend%0d", i), int'(rr8Pend), 8'h91);
        end
        rr8Req = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rr8.drained", int'(rr8Valid), 0);

        // round-robin N=5: wrap from 0 back to 4
        for (int i = 0; i < 5; i++) begin
            rr5Req   = 5'b10101;
            rr5Ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("rr5.valid%0d", i), int'(rr5Valid), 1);
            checkOutput($sformatf("rr5.y%0d", i), int'(rr5Y), int'(rr5Exp[i]));
            checkOutput($sformatf("rr5.inrange%0d", i), int'(rr5Y < 3'd5), 1);
        end
        rr5Req = 5'h00;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rr5.drained", int'(rr5Valid), 0);

        // asynchronous reset in the middle of an outstanding grant
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkMain("prereset", 1'b1, 3'd7, 8'hA5);
        req = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        checkMain("asyncreset", 1'b0, 3'd0, 8'h00);
        #3;
        rst_n = 1'b1;

`ifdef IRQ_MASK_EN
        mask8 = 8'h0F;
        applyStimulus(8'hF1, 1'b1, 1'b1);
        checkMain("mask0", 1'b1, 3'd0, 8'hF1);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask1", 1'b0, 3'd0, 8'hF0);
        mask8 = 8'hFF;
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask2", 1'b1, 3'd7, 8'hF0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask3", 1'b1, 3'd6, 8'h70);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask4", 1'b1, 3'd5, 8'h30);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask5", 1'b1, 3'd4, 8'h10);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkMain("mask6", 1'b0, 3'd4, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
